seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Parametrised, time-multiplexed seven-segment scan driver for the board's multi-digit hex display. It is the next-generation display block: digit count and scan rate are parameters, displayed data is double-buffered and committed on frame boundaries, and it adds per-digit decimal points, leading-zero suppression, blanking and lamp test. It sits between the CPU debug/status datapath (which supplies a packed hex word) and the display pins.

## Interface
Parameters:
- DIGITS, 8: number of digits scanned, any value ≥2, not restricted to a power of two.
- DIV_BITS, 11: scan divider width; dwell per digit is 2^DIV_BITS clk cycles.
- IDX_W, $clog2(DIGITS): width of `which`. Derived; not overridden.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- data  in  4*DIGITS  hex word. Digit 0, the leftmost, is data[4*DIGITS-1 -: 4].
- load  in  1  one-cycle strobe; capture `data` into the pending buffer.
- dp_mask  in  DIGITS  bit i=1 lights the dp of digit i. Bit DIGITS-1 is digit 0. Sampled live.
- lzs_en  in  1  leading-zero suppression enable. Sampled live.
- blank  in  1  all segments dark.
- lamp_test  in  1  all segments lit; overrides blank.
- which  out  IDX_W  digit select code, registered.
- seg  out  8  {a,b,c,d,e,f,g,dp}, active low (0 = lit), registered.
- frame_start  out  1  one-cycle pulse when `which` returns to 0.

## Operation
- Divider: `count` (DIV_BITS) increments every cycle. `tick` = &count.
- Digit index: on tick, idx <= (idx==DIGITS-1) ? 0 : idx+1. `boundary` = tick && idx==DIGITS-1.
- Buffering:
  - load: pending <= data, pend_v <= 1.
  - On boundary with pend_v: active <= pending, pend_v <= 0.
  - load and boundary in the same cycle: active <= data directly and pend_v <= 0. The newest load always wins.
- Segment selection for the digit at next idx, in priority order:
  - rst
  - lamp_test → 8'h00
  - blank → 8'hFF
  - leading-zero suppressed → 8'hFE if dp set, else 8'hFF
  - otherwise hex_to_seg(nibble) with seg[0] cleared if dp set.
- Hex table (dp bit = 1): 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09 A:11 B:C1 C:63 D:85 E:61 F:71.
- Leading-zero suppression: digit i is suppressed iff lzs_en and active digits 0..i are all 4'h0 and i≠DIGITS-1. The last digit always shows.
- frame_start <= boundary, so it is high in the same cycle `which` becomes 0.

## Timing
- Reset values: count 0, idx/which 0, seg 8'hFF, frame_start 0, active 0, pending 0, pend_v 0.
- which and seg are registered from the same next-state logic, so they always describe the same digit. There is no ghost cycle.
- Dwell is exactly 2^DIV_BITS cycles per digit. A frame is DIGITS·2^DIV_BITS cycles.
- Load-to-display latency is at most one frame + 1 cycle. It is never mid-frame, so there is no torn display.
- lamp_test, blank, lzs_en and dp_mask take effect on seg at the next posedge. Idx does not need to change.
- rst mid-frame: everything returns to reset values on the next posedge. A pending load is discarded.
- After reset the display shows active=0. With lzs_en=0 this is all "0" glyphs (8'h03).

## Structure
- Package seg_disp_pkg holds:
  - SEG_BLANK = 8'hFF
  - SEG_ALL_ON = 8'h00
  - SEG_DP_BIT = 0
  - function hex_to_seg(input [3:0]) returning [7:0] (dp = 1)
- Sub-module seg_hex_decoder: combinational nibble→segment decoder wrapping hex_to_seg. Instantiated once, on the selected nibble.
- Top holds the divider, index counter, buffers, LZS prefix-zero vector and output registers.

## Test plan
- Reset: hold rst 3 cycles mid-scan → seg=8'hFF, which=0, frame_start=0. After release the first tick comes 2^DIV_BITS cycles later.
- Scan/decode (DIGITS=8, DIV_BITS=2):
  - Stimulus: load 32'h0123_4567 at cycle 5.
  - At the first frame_start: which=0, seg=8'h03.
  - Each digit dwells 4 cycles: which=1 → 8'h9F, which=7 → 8'h1F.
  - After which=7, which returns to 0 with frame_start=1.
- Non-power-of-two (DIGITS=6): which sequence is 0,1,2,3,4,5,0. It never reaches 6 or 7. frame_start pulses once per 24 cycles.
- Double buffering:
  - Stimulus: load 32'hFFFF_FFFF while which=3.
  - Digits 3..7 still show the old values; new data appears from the next frame_start.
  - A load on the boundary cycle is displayed immediately at which=0.
- LZS and dp (DIGITS=8):
  - Stimulus: data 32'h0000_00A0, lzs_en=1, dp_mask=8'b0000_0010.
  - Required seg: digits 0–5 8'hFF, digit 6 8'h10 (A with dp lit), digit 7 8'h03.
  - With data 0 everywhere, only digit 7 shows 8'h03.
- Overrides: lamp_test=1 with blank=1 → seg=8'h00 for all digits. Drop lamp_test → 8'hFF. Drop blank → normal glyphs on the next cycle, with the scan position unchanged.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared constants and the hex-to-segment glyph table for the scanned display.
// Segment order is {a,b,c,d,e,f,g,dp}, active low.
package seg_disp_pkg;

   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam logic [7:0] SEG_ALL_ON = 8'h00;
   localparam int         SEG_DP_BIT = 0;

   // Glyphs are returned with the decimal point dark.
   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      logic [7:0] glyph;
      case (nib)
         4'h0: glyph = 8'h03;
         4'h1: glyph = 8'h9F;
         4'h2: glyph = 8'h25;
         4'h3: glyph = 8'h0D;
         4'h4: glyph = 8'h99;
         4'h5: glyph = 8'h49;
         4'h6: glyph = 8'h41;
         4'h7: glyph = 8'h1F;
         4'h8: glyph = 8'h01;
         4'h9: glyph = 8'h09;
         4'hA: glyph = 8'h11;
         4'hB: glyph = 8'hC1;
         4'hC: glyph = 8'h63;
         4'hD: glyph = 8'h85;
         4'hE: glyph = 8'h61;
         default: glyph = 8'h71;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/seg_scan_display_decoder.sv
// Combinational nibble-to-segment decoder; dp bit is always returned dark.
module seg_hex_decoder
   import seg_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] glyph
);

   assign glyph = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous double
// buffering, per-digit decimal points, leading-zero suppression and overrides.
module seg_scan_display
   import seg_disp_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int DIV_BITS = 11,
   parameter int IDX_W    = $clog2(DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data,
   input  logic                  load,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic                  lzs_en,
   input  logic                  blank,
   input  logic                  lamp_test,
   output logic [IDX_W-1:0]      which,
   output logic [7:0]            seg,
   output logic                  frame_start
);

   localparam int               SLOTS    = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   logic [DIV_BITS-1:0]  count_reg;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [4*DIGITS-1:0]  active_reg, active_next;
   logic [4*DIGITS-1:0]  pending_reg, pending_next;
   logic                 pend_v_reg, pend_v_next;
   logic [7:0]           seg_reg, seg_next;
   logic                 frame_start_reg;
   logic                 tick, boundary;

   // Per-slot views indexed by digit number (0 = leftmost); slots past
   // DIGITS-1 exist only so a full IDX_W-wide index is always in range.
   logic [3:0]           nib_arr [SLOTS];
   logic [SLOTS-1:0]     dp_vec;
   logic [SLOTS-1:0]     zero_prefix;
   logic [SLOTS-1:0]     lzs_vec;
   logic [3:0]           nibble_sel;
   logic [7:0]           glyph;

   assign tick     = &count_reg;
   assign boundary = tick && (idx_reg == LAST_IDX);

   assign idx_next = !tick ? idx_reg :
                     (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;

   // A load coinciding with the frame boundary goes straight to the active
   // buffer so the newest data always wins.
   always_comb begin
      active_next  = active_reg;
      pending_next = pending_reg;
      pend_v_next  = pend_v_reg;
      if (load) begin
         pending_next = data;
         pend_v_next  = 1'b1;
      end
      if (boundary) begin
         pend_v_next = 1'b0;
         if (load)
            active_next = data;
         else if (pend_v_reg)
            active_next = pending_reg;
      end
   end

   // Decode from active_next so seg matches which, even on the commit cycle.
   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < DIGITS) begin : g_real
         assign nib_arr[gi] = active_next[4*(DIGITS-1-gi) +: 4];
         assign dp_vec[gi]  = dp_mask[DIGITS-1-gi];
         if (gi == 0) begin : g_first
            assign zero_prefix[gi] = (nib_arr[gi] == 4'h0);
         end else begin : g_rest
            assign zero_prefix[gi] = zero_prefix[gi-1] && (nib_arr[gi] == 4'h0);
         end
         if (gi == DIGITS - 1) begin : g_last
            assign lzs_vec[gi] = 1'b0;
         end else begin : g_lead
            assign lzs_vec[gi] = lzs_en && zero_prefix[gi];
         end
      end else begin : g_pad
         assign nib_arr[gi]     = 4'h0;
         assign dp_vec[gi]      = 1'b0;
         assign zero_prefix[gi] = 1'b0;
         assign lzs_vec[gi]     = 1'b0;
      end
   end

   assign nibble_sel = nib_arr[idx_next];

   seg_hex_decoder u_decoder (
      .nibble (nibble_sel),
      .glyph  (glyph)
   );

   always_comb begin
      seg_next = glyph;
      if (lamp_test) begin
         seg_next = SEG_ALL_ON;
      end else if (blank) begin
         seg_next = SEG_BLANK;
      end else if (lzs_vec[idx_next]) begin
         seg_next = SEG_BLANK;
         if (dp_vec[idx_next])
            seg_next[SEG_DP_BIT] = 1'b0;
      end else if (dp_vec[idx_next]) begin
         seg_next[SEG_DP_BIT] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg       <= '0;
         idx_reg         <= '0;
         active_reg      <= '0;
         pending_reg     <= '0;
         pend_v_reg      <= 1'b0;
         seg_reg         <= SEG_BLANK;
         frame_start_reg <= 1'b0;
      end else begin
         count_reg       <= count_reg + 1'b1;
         idx_reg         <= idx_next;
         active_reg      <= active_next;
         pending_reg     <= pending_next;
         pend_v_reg      <= pend_v_next;
         seg_reg         <= seg_next;
         frame_start_reg <= boundary;
      end
   end

   assign which       = idx_reg;
   assign seg         = seg_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench: an 8-digit and a 6-digit instance, both with 4-cycle dwell.
module tb_seg_scan_display;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] data8;
   logic        load8, lzs8, blank8, lamp8;
   logic [7:0]  dp8;
   logic [2:0]  which8;
   logic [7:0]  seg8;
   logic        fs8;

   logic [23:0] data6;
   logic        load6, lzs6, blank6, lamp6;
   logic [5:0]  dp6;
   logic [2:0]  which6;
   logic [7:0]  seg6;
   logic        fs6;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_scan [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};
   logic [7:0] exp_lzs  [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h10, 8'h03};

   always #5 clk = ~clk;

   seg_scan_display #(.DIGITS(8), .DIV_BITS(2)) dut8 (
      .clk(clk), .rst(rst), .data(data8), .load(load8), .dp_mask(dp8),
      .lzs_en(lzs8), .blank(blank8), .lamp_test(lamp8),
      .which(which8), .seg(seg8), .frame_start(fs8)
   );

   seg_scan_display #(.DIGITS(6), .DIV_BITS(2)) dut6 (
      .clk(clk), .rst(rst), .data(data6), .load(load6), .dp_mask(dp6),
      .lzs_en(lzs6), .blank(blank6), .lamp_test(lamp6),
      .which(which6), .seg(seg6), .frame_start(fs6)
   );

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_fs8(input string name);
      int n = 0;
      while (!fs8 && n < 80) begin
         cyc();
         n++;
      end
      total++;
      if (!fs8) begin
         bad++;
         $display("FAIL %s: frame_start timeout got=%0b want=1", name, fs8);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(10);
      // pending load must be discarded by a mid-frame reset
      data8 = 32'hFFFF_FFFF;
      load8 = 1'b1;
      cyc();
      load8 = 1'b0;
      rst   = 1'b1;
      cyc(3);
      total++;
      if (seg8 !== 8'hFF) begin bad++; $display("FAIL reset_seg: got=%h want=ff", seg8); end
      total++;
      if (which8 !== 3'd0) begin bad++; $display("FAIL reset_which: got=%0d want=0", which8); end
      total++;
      if (fs8 !== 1'b0) begin bad++; $display("FAIL reset_fs: got=%0b want=0", fs8); end
      rst = 1'b0;
      cyc();
      total++;
      if (seg8 !== 8'h03) begin bad++; $display("FAIL reset_first_glyph: got=%h want=03", seg8); end
      cyc(2);
      total++;
      if (which8 !== 3'd0) begin bad++; $display("FAIL reset_no_early_tick: got=%0d want=0", which8); end
      cyc();
      total++;
      if (which8 !== 3'd1) begin bad++; $display("FAIL reset_first_tick: got=%0d want=1", which8); end
      wait_fs8("reset_frame");
      cyc();
      total++;
      if (seg8 !== 8'h03) begin bad++; $display("FAIL reset_load_discarded: got=%h want=03", seg8); end
      $display("test_reset done");
   endtask

   task automatic test_scan();
      data8 = 32'h0123_4567;
      load8 = 1'b1;
      cyc();
      load8 = 1'b0;
      wait_fs8("scan_wait");
      for (int d = 0; d < 8; d++) begin
         for (int k = 0; k < 4; k++) begin
            total++;
            if (which8 !== d[2:0]) begin bad++; $display("FAIL scan_which d=%0d k=%0d: got=%0d want=%0d", d, k, which8, d); end
            total++;
            if (seg8 !== exp_scan[d]) begin bad++; $display("FAIL scan_seg d=%0d k=%0d: got=%h want=%h", d, k, seg8, exp_scan[d]); end
            total++;
            if (fs8 !== (d == 0 && k == 0)) begin bad++; $display("FAIL scan_fs d=%0d k=%0d: got=%0b", d, k, fs8); end
            cyc();
         end
      end
      total++;
      if (which8 !== 3'd0 || fs8 !== 1'b1) begin
         bad++;
         $display("FAIL scan_wrap: which=%0d fs=%0b want which=0 fs=1", which8, fs8);
      end
      $display("test_scan done");
   endtask

   task automatic test_non_pow2();
      int n = 0;
      while (!fs6 && n < 60) begin cyc(); n++; end
      total++;
      if (!fs6) begin bad++; $display("FAIL np2_wait: frame_start timeout got=0 want=1"); end
      for (int k = 0; k < 24; k++) begin
         total++;
         if (which6 !== 3'(k / 4)) begin bad++; $display("FAIL np2_which k=%0d: got=%0d want=%0d", k, which6, k / 4); end
         total++;
         if (fs6 !== (k == 0)) begin bad++; $display("FAIL np2_fs k=%0d: got=%0b", k, fs6); end
         cyc();
      end
      total++;
      if (which6 !== 3'd0 || fs6 !== 1'b1) begin
         bad++;
         $display("FAIL np2_wrap: which=%0d fs=%0b want which=0 fs=1", which6, fs6);
      end
      total++;
      if (seg6 !== 8'h03) begin bad++; $display("FAIL np2_seg: got=%h want=03", seg6); end
      $display("test_non_pow2 done");
   endtask

   task automatic test_double_buffer();
      int n = 0;
      while (which8 !== 3'd3 && n < 40) begin cyc(); n++; end
      data8 = 32'hFFFF_FFFF;
      load8 = 1'b1;
      cyc();
      load8 = 1'b0;
      n = 0;
      while (!fs8 && n < 40) begin
         total++;
         if (seg8 !== exp_scan[which8]) begin bad++; $display("FAIL dbuf_old which=%0d: got=%h want=%h", which8, seg8, exp_scan[which8]); end
         cyc();
         n++;
      end
      wait_fs8("dbuf_commit");
      for (int k = 0; k < 32; k++) begin
         total++;
         if (seg8 !== 8'h71) begin bad++; $display("FAIL dbuf_new k=%0d: got=%h want=71", k, seg8); end
         cyc();
      end
      n = 0;
      while (which8 !== 3'd7 && n < 40) begin cyc(); n++; end
      cyc(3);
      data8 = 32'h89AB_CDEF;
      load8 = 1'b1;
      cyc();
      load8 = 1'b0;
      total++;
      if (fs8 !== 1'b1 || which8 !== 3'd0 || seg8 !== 8'h01) begin
         bad++;
         $display("FAIL dbuf_boundary: fs=%0b which=%0d seg=%h want fs=1 which=0 seg=01", fs8, which8, seg8);
      end
      cyc(4);
      total++;
      if (which8 !== 3'd1 || seg8 !== 8'h09) begin
         bad++;
         $display("FAIL dbuf_boundary_d1: which=%0d seg=%h want which=1 seg=09", which8, seg8);
      end
      $display("test_double_buffer done");
   endtask

   task automatic test_lzs_dp();
      data8 = 32'h0000_00A0;
      lzs8  = 1'b1;
      dp8   = 8'b0000_0010;
      load8 = 1'b1;
      cyc();
      load8 = 1'b0;
      cyc();
      wait_fs8("lzs_wait");
      for (int d = 0; d < 8; d++) begin
         total++;
         if (seg8 !== exp_lzs[d]) begin bad++; $display("FAIL lzs_seg d=%0d: got=%h want=%h", d, seg8, exp_lzs[d]); end
         cyc(4);
      end
      dp8   = 8'h00;
      data8 = 32'h0000_0000;
      load8 = 1'b1;
      cyc();
      load8 = 1'b0;
      cyc();
      wait_fs8("lzs_zero_wait");
      for (int d = 0; d < 8; d++) begin
         total++;
         if (seg8 !== ((d == 7) ? 8'h03 : 8'hFF)) begin bad++; $display("FAIL lzs_zero d=%0d: got=%h", d, seg8); end
         cyc(4);
      end
      lzs8 = 1'b0;
      $display("test_lzs_dp done");
   endtask

   task automatic test_overrides();
      logic [2:0] saved;
      data8 = 32'h0123_4567;
      load8 = 1'b1;
      cyc();
      load8 = 1'b0;
      cyc();
      wait_fs8("ovr_wait");
      lamp8  = 1'b1;
      blank8 = 1'b1;
      for (int k = 0; k < 32; k++) begin
         cyc();
         total++;
         if (seg8 !== 8'h00) begin bad++; $display("FAIL ovr_lamp k=%0d: got=%h want=00", k, seg8); end
      end
      lamp8 = 1'b0;
      cyc();
      total++;
      if (seg8 !== 8'hFF) begin bad++; $display("FAIL ovr_blank: got=%h want=ff", seg8); end
      saved  = which8;
      blank8 = 1'b0;
      cyc();
      total++;
      if (which8 !== saved) begin bad++; $display("FAIL ovr_pos: got=%0d want=%0d", which8, saved); end
      total++;
      if (seg8 !== 8'h03) begin bad++; $display("FAIL ovr_restore: got=%h want=03", seg8); end
      $display("test_overrides done");
   endtask

   initial begin
      rst = 1'b1;
      data8 = '0; load8 = 1'b0; dp8 = '0; lzs8 = 1'b0; blank8 = 1'b0; lamp8 = 1'b0;
      data6 = '0; load6 = 1'b0; dp6 = '0; lzs6 = 1'b0; blank6 = 1'b0; lamp6 = 1'b0;
      test_reset();
      test_scan();
      test_non_pow2();
      test_double_buffer();
      test_lzs_dp();
      test_overrides();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
